// File: rtl/uart_frame_streamer.sv
// -----------------------------------------------------------------------------
// uart_frame_streamer
//
// Purpose:
//   Turns a finished interpolation run into a self-describing byte stream for
//   the host. On an accepted start it sends one frame on a byte-wide
//   valid/ready port:
//     SYNC_BYTE, width[15:8], width[7:0], height[15:8], height[7:0],
//     width*height pixel bytes read from result-buffer addresses 0..N-1,
//     and, when UART_FRAME_CHECKSUM_EN is defined, a modulo-256 checksum of
//     every byte after the sync byte.
//
// Optional feature macro:
//   UART_FRAME_CHECKSUM_EN - compiles in the checksum accumulator and the
//                            CSUM state. Undefined by default.
//
// Ports:
//   clk          in   single clock
//   rst_n        in   synchronous, active-low reset
//   start        in   one-cycle frame request, honoured only while idle
//   width        in   image width in pixels, latched on accepted start
//   height       in   image height in pixels, latched on accepted start
//   busy         out  high from the cycle after an accepted start until done
//   done         out  one-cycle pulse after the final byte has been handed off
//   mem_rd_en    out  result-buffer read strobe
//   mem_addr     out  result-buffer read address
//   mem_rdata    in   read data, valid exactly one cycle after mem_rd_en
//   tx_data      out  byte to the UART transmitter
//   tx_valid     out  tx_data is valid
//   tx_ready     in   UART transmitter can accept
//   o_dbg_state  out  current FSM state, for debug and checker binding
//
// Handshake:
//   A byte transfers on a rising edge where tx_valid && tx_ready. Once
//   tx_valid is raised it stays high with tx_data stable until that transfer
//   happens; it only drops without a transfer on reset.
// -----------------------------------------------------------------------------
module uart_frame_streamer #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter logic [7:0]  SYNC_BYTE  = 8'hA5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [15:0]           width,
    input  logic [15:0]           height,
    output logic                  busy,
    output logic                  done,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [7:0]            mem_rdata,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic [2:0]            o_dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HDR   = 3'd1,
        S_FETCH = 3'd2,
        S_WAIT  = 3'd3,
        S_SEND  = 3'd4,
        S_FIN   = 3'd5
`ifdef UART_FRAME_CHECKSUM_EN
        , S_CSUM = 3'd6
`endif
    } state_t;

    // State entered once the last header byte or last pixel has transferred.
`ifdef UART_FRAME_CHECKSUM_EN
    localparam state_t TAIL_STATE = S_CSUM;
`else
    localparam state_t TAIL_STATE = S_FIN;
`endif

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
    localparam logic [2:0]            HDR_LAST = 3'd4;

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    state_t                r_state;
    logic [15:0]           r_width;
    logic [15:0]           r_height;
    logic [31:0]           r_pix_left;   // pixels not yet fetched
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [2:0]            r_hdr_idx;    // header byte currently presented
    logic [7:0]            r_pix_data;   // pixel captured in WAIT
`ifdef UART_FRAME_CHECKSUM_EN
    logic [7:0]            r_csum;
`endif

    // -------------------------------------------------------------------------
    // Wires
    // -------------------------------------------------------------------------
    state_t      w_next_state;
    logic        w_hs;
    logic [7:0]  w_hdr_byte;
    logic [31:0] w_npix;

    // Full 32-bit product so no dimension pair can overflow the pixel count.
    assign w_npix = {16'd0, width} * {16'd0, height};

    assign w_hs = tx_valid && tx_ready;

    always_comb begin
        w_hdr_byte = 8'h00;
        case (r_hdr_idx)
            3'd0:    w_hdr_byte = SYNC_BYTE;
            3'd1:    w_hdr_byte = r_width[15:8];
            3'd2:    w_hdr_byte = r_width[7:0];
            3'd3:    w_hdr_byte = r_height[15:8];
            3'd4:    w_hdr_byte = r_height[7:0];
            default: w_hdr_byte = 8'h00;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next_state = S_HDR;
                end
            end
            S_HDR: begin
                // r_pix_left still holds N here, so N = 0 skips straight on.
                if (w_hs && (r_hdr_idx == HDR_LAST)) begin
                    w_next_state = (r_pix_left != 32'd0) ? S_FETCH : TAIL_STATE;
                end
            end
            S_FETCH: begin
                w_next_state = S_WAIT;
            end
            S_WAIT: begin
                w_next_state = S_SEND;
            end
            S_SEND: begin
                // r_pix_left was decremented in FETCH, so it counts the
                // pixels after the one being sent now.
                if (w_hs) begin
                    w_next_state = (r_pix_left != 32'd0) ? S_FETCH : TAIL_STATE;
                end
            end
`ifdef UART_FRAME_CHECKSUM_EN
            S_CSUM: begin
                if (w_hs) begin
                    w_next_state = S_FIN;
                end
            end
`endif
            S_FIN: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs (Moore, decoded from the registered state)
    // -------------------------------------------------------------------------
    always_comb begin
        busy      = (r_state != S_IDLE) && (r_state != S_FIN);
        done      = (r_state == S_FIN);
        mem_rd_en = (r_state == S_FETCH);
        tx_valid  = 1'b0;
        tx_data   = 8'h00;
        case (r_state)
            S_HDR: begin
                tx_valid = 1'b1;
                tx_data  = w_hdr_byte;
            end
            S_SEND: begin
                tx_valid = 1'b1;
                tx_data  = r_pix_data;
            end
`ifdef UART_FRAME_CHECKSUM_EN
            S_CSUM: begin
                tx_valid = 1'b1;
                tx_data  = r_csum;
            end
`endif
            default: begin
                tx_valid = 1'b0;
                tx_data  = 8'h00;
            end
        endcase
    end

    assign mem_addr    = r_addr;
    assign o_dbg_state = r_state;

    // -------------------------------------------------------------------------
    // Datapath
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_width    <= 16'd0;
            r_height   <= 16'd0;
            r_pix_left <= 32'd0;
            r_addr     <= '0;
            r_hdr_idx  <= 3'd0;
            r_pix_data <= 8'h00;
`ifdef UART_FRAME_CHECKSUM_EN
            r_csum     <= 8'h00;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_width    <= width;
                        r_height   <= height;
                        r_pix_left <= w_npix;
                        r_addr     <= '0;
                        r_hdr_idx  <= 3'd0;
`ifdef UART_FRAME_CHECKSUM_EN
                        r_csum     <= 8'h00;
`endif
                    end
                end
                S_HDR: begin
                    if (w_hs) begin
                        r_hdr_idx <= r_hdr_idx + 3'd1;
`ifdef UART_FRAME_CHECKSUM_EN
                        // The sync byte is not part of the checksum.
                        if (r_hdr_idx != 3'd0) begin
                            r_csum <= r_csum + w_hdr_byte;
                        end
`endif
                    end
                end
                S_FETCH: begin
                    r_addr     <= r_addr + ADDR_ONE;
                    r_pix_left <= r_pix_left - 32'd1;
                end
                S_WAIT: begin
                    r_pix_data <= mem_rdata;
                end
                S_SEND: begin
`ifdef UART_FRAME_CHECKSUM_EN
                    if (w_hs) begin
                        r_csum <= r_csum + r_pix_data;
                    end
`endif
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_frame_streamer.sv
// -----------------------------------------------------------------------------
// tb_uart_frame_streamer
//
// Drives whole frames through uart_frame_streamer with directed and random
// dimensions, random memory contents and random tx_ready back-pressure. The
// expected byte stream of each frame is built up front from the frame rules
// (header, raster pixels, optional modulo-256 sum); a per-cycle expectation
// of valid / read strobe / done is derived from the latency rules.
// -----------------------------------------------------------------------------
module tb_uart_frame_streamer;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] width;
  logic [15:0] height;
  logic        busy;
  logic        done;
  logic        mem_rd_en;
  logic [15:0] mem_addr;
  logic [7:0]  mem_rdata;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [2:0]  dbg_state;

  always #5 clk = ~clk;

  uart_frame_streamer #(
    .ADDR_WIDTH (16),
    .SYNC_BYTE  (8'hA5)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .width       (width),
    .height      (height),
    .busy        (busy),
    .done        (done),
    .mem_rd_en   (mem_rd_en),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .o_dbg_state (dbg_state)
  );

  // Result-buffer model: data is valid only in the cycle after the strobe,
  // garbage otherwise.
  logic [7:0] mem [0:255];

  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= mem[mem_addr[7:0]];
    else           mem_rdata <= 8'($urandom);
  end

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic build_expected(input logic [15:0] w, input logic [15:0] h);
    int         npix;
    logic [7:0] sum;
    exp_q.delete();
    exp_q.push_back(8'hA5);
    exp_q.push_back(w[15:8]);
    exp_q.push_back(w[7:0]);
    exp_q.push_back(h[15:8]);
    exp_q.push_back(h[7:0]);
    npix = int'(w) * int'(h);
    for (int i = 0; i < npix; i++) exp_q.push_back(mem[i % 256]);
`ifdef UART_FRAME_CHECKSUM_EN
    sum = 8'h00;
    for (int i = 1; i < exp_q.size(); i++) sum = sum + exp_q[i];
    exp_q.push_back(sum);
`else
    sum = 8'h00;
`endif
  endtask

  task automatic check_reset_values(input string where);
    check_eq({where, "_busy"},   32'(busy),      32'd0);
    check_eq({where, "_done"},   32'(done),      32'd0);
    check_eq({where, "_valid"},  32'(tx_valid),  32'd0);
    check_eq({where, "_data"},   32'(tx_data),   32'd0);
    check_eq({where, "_rd_en"},  32'(mem_rd_en), 32'd0);
    check_eq({where, "_addr"},   32'(mem_addr),  32'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Driver: one frame, checked cycle by cycle.
  //   ready_pct       : probability (%) of tx_ready each cycle
  //   stall_idx/len   : hold tx_ready low for stall_len cycles when byte
  //                     stall_idx is presented (-1 = none)
  //   busy_start_idx  : pulse start with width=3 while byte is presented
  //   abort_idx       : pulse rst_n low while byte is presented
  // ---------------------------------------------------------------------------
  task automatic run_frame(input logic [15:0] w, input logic [15:0] h, input int ready_pct,
                           input int stall_idx, input int stall_len,
                           input int busy_start_idx, input int abort_idx);
    int         npix, total, hs_cnt, wait_cnt, cyc, stall_left, rd_cnt;
    bit         exp_rd, exp_done, next_rd, next_done, hs, finished;
    bit         prev_hold, stalled_once, busy_start_done;
    logic [7:0] prev_data, want;

    build_expected(w, h);
    npix  = int'(w) * int'(h);
    total = exp_q.size();

    @(negedge clk);
    check_eq("idle_busy",  32'(busy),     32'd0);
    check_eq("idle_done",  32'(done),     32'd0);
    check_eq("idle_valid", 32'(tx_valid), 32'd0);
    width  = w;
    height = h;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    width  = 16'($urandom);
    height = 16'($urandom);

    hs_cnt = 0; wait_cnt = 0; cyc = 0; stall_left = 0; rd_cnt = 0;
    exp_rd = 0; exp_done = 0; finished = 0; prev_hold = 0;
    stalled_once = 0; busy_start_done = 0; prev_data = 8'h00;

    while (!finished) begin
      if (cyc > 5000) begin
        check_eq("frame_timeout", 32'd1, 32'd0);
        tx_ready = 1'b0;
        return;
      end
      check_eq("busy",  32'(busy),      32'(!exp_done));
      check_eq("done",  32'(done),      32'(exp_done));
      check_eq("rd_en", 32'(mem_rd_en), 32'(exp_rd));
      if (exp_rd) check_eq("rd_addr", 32'(mem_addr), 32'(rd_cnt));
      if (mem_rd_en) rd_cnt++;
      check_eq("valid", 32'(tx_valid), 32'(!exp_done && wait_cnt == 0));
      if (prev_hold) check_eq("hold_data", 32'(tx_data), 32'(prev_data));

      if (exp_done) begin
        finished = 1;
      end else begin
        if (abort_idx == hs_cnt && tx_valid) begin
          tx_ready = 1'b0;
          rst_n    = 1'b0;
          @(negedge clk);
          rst_n    = 1'b1;
          check_reset_values("abort");
          for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("abort_no_done", 32'(done), 32'd0);
            check_eq("abort_idle",    32'(busy), 32'd0);
          end
          exp_q.delete();
          return;
        end

        if (stall_idx == hs_cnt && tx_valid && !stalled_once) begin
          stall_left   = stall_len;
          stalled_once = 1;
        end
        if (stall_left > 0) begin
          tx_ready = 1'b0;
          stall_left--;
        end else begin
          tx_ready = (int'($urandom_range(99, 0)) < ready_pct);
        end

        if (busy_start_idx == hs_cnt && !busy_start_done) begin
          start           = 1'b1;
          width           = 16'd3;
          busy_start_done = 1;
        end else begin
          start = 1'b0;
        end

        hs        = tx_valid && tx_ready;
        prev_hold = tx_valid && !tx_ready;
        prev_data = tx_data;
        next_rd   = 0;
        next_done = 0;
        if (hs) begin
          if (exp_q.size() == 0) begin
            check_eq("extra_byte", 32'd1, 32'd0);
          end else begin
            want = exp_q.pop_front();
            check_eq("tx_byte", 32'(tx_data), 32'(want));
          end
          hs_cnt++;
          if (hs_cnt == total) begin
            next_done = 1;
          end else if (hs_cnt >= 5 && hs_cnt < 5 + npix) begin
            wait_cnt = 2;
            next_rd  = 1;
          end else begin
            wait_cnt = 0;
          end
        end else if (wait_cnt > 0) begin
          wait_cnt--;
        end
        exp_rd   = next_rd;
        exp_done = next_done;
        @(negedge clk);
        cyc++;
      end
    end
    start    = 1'b0;
    tx_ready = 1'b0;
    check_eq("rd_count",   32'(rd_cnt),       32'(npix));
    check_eq("bytes_left", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic load_directed_mem();
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h0A;
    mem[1] = 8'h14;
    mem[2] = 8'h1E;
    mem[3] = 8'h28;
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic [15:0] rw, rh;
    int          sel;

    rst_n    = 1'b0;
    start    = 1'b0;
    width    = 16'd0;
    height   = 16'd0;
    tx_ready = 1'b0;
    load_directed_mem();
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;

    // 2x2 frame, ready always high.
    run_frame(16'd2, 16'd2, 100, -1, 0, -1, -1);
    // Back-pressure for 100 cycles on pixel 1E.
    run_frame(16'd2, 16'd2, 100, 7, 100, -1, -1);
    // Zero dimension: header (plus checksum) only.
    run_frame(16'd0, 16'd5, 100, -1, 0, -1, -1);
    // Start with a new width while busy, in the header and in the pixels.
    run_frame(16'd2, 16'd2, 100, -1, 0, 2, -1);
    run_frame(16'd2, 16'd2, 70, -1, 0, 6, -1);
    // Reset mid-frame during the third pixel, then a fresh frame.
    run_frame(16'd2, 16'd2, 100, -1, 0, -1, 7);
    run_frame(16'd2, 16'd2, 100, -1, 0, -1, -1);

    // Random frames.
    for (int n = 0; n < 16; n++) begin
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      sel = int'($urandom_range(9, 0));
      if (sel == 0) begin
        rw = 16'($urandom_range(65535, 256));
        rh = 16'd0;
      end else if (sel == 1) begin
        rw = 16'd0;
        rh = 16'($urandom_range(65535, 256));
      end else begin
        rw = 16'($urandom_range(6, 0));
        rh = 16'($urandom_range(6, 0));
      end
      run_frame(rw, rh, int'($urandom_range(100, 30)),
                (sel == 5) ? int'($urandom_range(8, 0)) : -1,
                int'($urandom_range(20, 1)), -1, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "simulation watchdog expired");
  end

endmodule

// File: doc/uart_frame_streamer.md
# uart_frame_streamer

Upstream feeder for the UART transmitter: on a start pulse it streams one interpolated output image from the result buffer onto a byte-wide valid/ready port. The frame is a fixed header, the pixel bytes in raster order, and an optional checksum. It sits between the result-image RAM read port and the UART TX byte input. It turns a finished interpolation run into a self-describing byte stream for the host.

## Interface
- `ADDR_WIDTH`, 16, result-buffer address width; pixel addresses wrap modulo 2^ADDR_WIDTH.
- `SYNC_BYTE`, 8'hA5, first byte of every frame.
- `clk`  in  1  single clock.
- `rst_n`  in  1  reset, synchronous and active-low.
- `start`  in  1  one-cycle request to send a frame; honoured only when not busy.
- `width`  in  16  image width in pixels, latched on accepted start.
- `height`  in  16  image height in pixels, latched on accepted start.
- `busy`  out  1  high from the cycle after an accepted start until `done`.
- `done`  out  1  one-cycle pulse when the frame has been fully handed off.
- `mem_rd_en`  out  1  result-buffer read strobe.
- `mem_addr`  out  ADDR_WIDTH  result-buffer read address.
- `mem_rdata`  in  8  read data, valid exactly one cycle after `mem_rd_en`.
- `tx_data`  out  8  byte to UART TX.
- `tx_valid`  out  1  `tx_data` is valid.
- `tx_ready`  in  1  UART TX can accept; transfer occurs on an edge where `tx_valid && tx_ready`.

## Operation
- Frame byte order:
  - `SYNC_BYTE`
  - width[15:8], width[7:0]
  - height[15:8], height[7:0]
  - N = width*height pixel bytes from addresses 0..N-1
  - checksum, only when configured
- N is computed as a 32-bit product at start. Address increments modulo 2^ADDR_WIDTH.
- If width or height is 0, then N = 0: no `mem_rd_en` is issued, and the header (plus checksum if configured) is still sent.
- FSM states and transitions:
  - IDLE: wait for `start`.
  - HDR: send 5 header bytes, tracked by a 3-bit index.
  - FETCH: assert `mem_rd_en` for 1 cycle at the current address.
  - WAIT: capture `mem_rdata` into `tx_data`.
  - SEND: hold until handshake, then go to FETCH if pixels remain, else CSUM or FIN.
  - CSUM: send the checksum byte.
  - FIN: pulse `done`, return to IDLE.
- Checksum is the 8-bit modulo-256 sum of every byte after the sync byte (header dimension bytes and pixels).
- `start` while busy is ignored. Changes on `width`/`height` after the latch have no effect.
- Exactly one read is issued per pixel. No prefetch.

## Timing
- Reset values: `busy` 0, `done` 0, `tx_valid` 0, `tx_data` 8'h00, `mem_rd_en` 0, `mem_addr` 0, FSM in IDLE, checksum 0.
- Start is accepted at edge k. At edge k+1: `busy`=1, `tx_valid`=1, `tx_data`=`SYNC_BYTE`.
- Header bytes: the next byte is presented the cycle after each handshake, so back-to-back transfers are possible.
- Pixel path:
  - The handshake of the previous byte moves the FSM to FETCH.
  - `mem_rd_en`=1 for one cycle.
  - WAIT captures the data.
  - `tx_valid` rises 2 cycles after the previous handshake.
- While `tx_valid && !tx_ready`, `tx_data` is stable and `tx_valid` stays high. `tx_valid` never drops without a handshake, except on reset.
- `tx_valid` deasserts the cycle after the last byte's handshake. `done`=1 and `busy`=0 in that same cycle, and `done` lasts exactly one cycle.
- A new `start` is accepted in the cycle after `done`.
- `rst_n` low at any edge, including mid-frame: all outputs return to reset values at that edge. The frame is abandoned and no `done` is issued.

## Configuration
- `UART_FRAME_CHECKSUM_EN` defined: the checksum accumulator is compiled in, and the checksum byte is sent after the last pixel (or after the header when N = 0).
- `UART_FRAME_CHECKSUM_EN` not defined: no accumulator and no CSUM state. `done` follows the last pixel's handshake (or the last header byte when N = 0).

## Test plan
- **2x2 frame, checksum on.** Memory holds 0A 14 1E 28; `tx_ready` tied 1 → bytes A5 00 02 00 02 0A 14 1E 28 68, exactly 4 `mem_rd_en` pulses at addresses 0..3, one `done`.
- **Back-pressure.** Same frame with `tx_ready` low for 100 cycles during pixel 1E → `tx_data`=1E and `tx_valid`=1 held throughout, no extra `mem_rd_en`, stream identical to the first test.
- **Zero dimension.** width=0, height=5 → bytes A5 00 00 00 05 05, no `mem_rd_en`, `done` pulse.
- **Start and inputs ignored while busy.** `start` pulsed mid-frame with width changed to 3 → no restart, header stays 00 02, single `done`.
- **Reset mid-frame.** `rst_n` low 1 cycle during pixel 3 → next cycle `tx_valid`=0, `busy`=0, no `done`; a following `start` sends a complete fresh frame starting with A5.
- **Macro undefined.** 2x2 frame → 9 bytes ending with 28, `done` the cycle after the handshake of 28.
